// File: rtl/alu_mdu_controller_pkg.sv
// Shared encodings for the RV32 ALU control / multiply-divide unit:
// base-ALU operation codes, M-group function codes and MDU sequencer states.
package alu_mdu_controller_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1100;
  localparam logic [3:0] OP_JAL  = 4'b1101;
  localparam logic [3:0] OP_SLTU = 4'b1110;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_JUMP   = 2'b11;

  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [6:0] F7_MDU = 7'b0000001;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

  function automatic logic [3:0] decode_operation(input logic [1:0] aluop,
                                                  input logic [6:0] f7,
                                                  input logic [2:0] f3);
    logic [3:0] op;
    op = OP_AND;
    case (aluop)
      ALUOP_MEM:    op = OP_ADD;
      ALUOP_BRANCH: op = OP_BEQ;
      ALUOP_JUMP:   op = OP_JAL;
      default: begin
        case (f3)
          3'b000:  op = (f7 == F7_ALT) ? OP_SUB : OP_ADD;
          3'b001:  op = OP_SLL;
          3'b010:  op = OP_SLT;
          3'b011:  op = OP_SLTU;
          3'b100:  op = OP_XOR;
          3'b101:  op = (f7 == F7_ALT) ? OP_SRA : OP_SRL;
          3'b110:  op = OP_OR;
          default: op = OP_AND;
        endcase
      end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_mdu_controller_md_iter_datapath.sv
// Radix-2 iterative multiply/divide datapath: magnitude load, one shift-add or
// restoring-subtract step per cycle, and the final sign fix-up of the result.
module alu_mdu_controller_md_iter_datapath
  import alu_mdu_controller_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             fast,
  output logic [WIDTH-1:0] fix_res
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] fix_sign(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] s;
    s = v;
    return neg ? -s : s;
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_sign_wide(input logic [2*WIDTH-1:0] v,
                                                       input logic neg);
    logic signed [2*WIDTH-1:0] s;
    s = v;
    return neg ? -s : s;
  endfunction

  mdu_op_e          op_in, op;
  logic             sgn_a, sgn_b, neg_in, div_zero, div_ovf, neg;
  logic [WIDTH-1:0] fast_val;
  logic [WIDTH-1:0] hi, lo, mag_b, hi_nxt, lo_nxt, diff;
  logic [WIDTH:0]   sum, shifted;
  logic [2*WIDTH-1:0] prod;

  assign op_in = mdu_op_e'(funct3);

  always_comb begin
    sgn_a    = (op_in inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM}) && src_a[WIDTH-1];
    sgn_b    = (op_in inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM}) && src_b[WIDTH-1];
    // remainder follows the dividend; products and quotients follow the sign product
    neg_in   = (op_in == MDU_REM) ? sgn_a : (sgn_a ^ sgn_b);
    div_zero = funct3[2] && (src_b == '0);
    div_ovf  = (op_in inside {MDU_DIV, MDU_REM}) && (src_a == MIN_NEG) && (&src_b);
    fast_val = '0;
    if (div_zero)
      fast_val = funct3[1] ? src_a : '1;
    else if (div_ovf)
      fast_val = funct3[1] ? '0 : src_a;
  end

  // Accept stage: magnitudes in, fast-path answer parked in hi
  always_ff @(posedge clk) begin
    if (load) begin
      op    <= op_in;
      neg   <= neg_in;
      fast  <= div_zero | div_ovf;
      mag_b <= fix_sign(src_b, sgn_b);
      lo    <= fix_sign(src_a, sgn_a);
      hi    <= fast_val;
    end else if (step) begin
      hi <= hi_nxt;
      lo <= lo_nxt;
    end
  end

  // Iteration stage: multiplier bits leave lo from the bottom, quotient bits enter it
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - mag_b;
    if (op[2]) begin
      if (shifted >= {1'b0, mag_b}) begin
        hi_nxt = diff;
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], lo[WIDTH-1:1]};
    end
  end

  // Fix-up stage
  always_comb begin
    prod = fix_sign_wide({hi, lo}, neg);
    case (op)
      MDU_MUL:                        fix_res = prod[WIDTH-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = prod[2*WIDTH-1:WIDTH];
      MDU_DIV, MDU_DIVU:              fix_res = fix_sign(lo, neg);
      default:                        fix_res = fix_sign(hi, neg);
    endcase
    if (fast)
      fix_res = hi;
  end

endmodule

// File: rtl/alu_mdu_controller.sv
// EX-stage ALU control decode plus the RV32M sequencer: decodes the base-ALU
// operation, detects M-group ops and runs them through the iterative MDU.
module alu_mdu_controller
  import alu_mdu_controller_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter bit HAS_MDU = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic [3:0]       Operation,
  output logic             is_mdu,
  output logic             illegal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] md_result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic m_group;

  assign m_group   = (ALUOp == ALUOP_RTYPE) && (Funct7 == F7_MDU);
  assign Operation = decode_operation(ALUOp, Funct7, Funct3);
  assign is_mdu    = HAS_MDU && m_group;
  assign illegal   = !HAS_MDU && m_group;

  generate
    if (HAS_MDU) begin : g_mdu
      mdu_state_e       state, state_nxt;
      logic [CNT_W-1:0] cnt;
      logic             accept, fast, last_iter;
      logic [WIDTH-1:0] fix_res;

      // flush in IDLE holds off a new op for that cycle
      assign accept    = (state == ST_IDLE) && in_valid && is_mdu && !flush;
      assign last_iter = fast || (cnt == CNT_W'(WIDTH - 1));

      always_ff @(posedge clk) begin
        if (reset)
          state <= ST_IDLE;
        else
          state <= state_nxt;
      end

      always_comb begin
        state_nxt = state;
        case (state)
          ST_IDLE: if (accept) state_nxt = ST_CALC;
          ST_CALC: begin
            if (flush)
              state_nxt = ST_IDLE;
            else if (last_iter)
              state_nxt = ST_FIX;
          end
          ST_FIX:  state_nxt = flush ? ST_IDLE : ST_DONE;
          ST_DONE: if (flush || out_ready) state_nxt = ST_IDLE;
          default: state_nxt = ST_IDLE;
        endcase
      end

      always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
      end

      always_ff @(posedge clk) begin
        if (reset)
          cnt <= '0;
        else if (state == ST_CALC && !flush)
          cnt <= cnt + CNT_W'(1);
        else
          cnt <= '0;
      end

      // Result register: loads once per op, otherwise holds for MEM
      always_ff @(posedge clk) begin
        if (reset)
          md_result <= '0;
        else if (state == ST_FIX && !flush)
          md_result <= fix_res;
      end

      alu_mdu_controller_md_iter_datapath #(
        .WIDTH(WIDTH)
      ) u_datapath (
        .clk    (clk),
        .load   (accept),
        .step   ((state == ST_CALC) && !fast),
        .funct3 (Funct3),
        .src_a  (src_a),
        .src_b  (src_b),
        .fast   (fast),
        .fix_res(fix_res)
      );
    end else begin : g_no_mdu
      assign in_ready  = 1'b1;
      assign out_valid = 1'b0;
      assign md_result = '0;
    end
  endgenerate

endmodule

// File: tb/tb_alu_mdu_controller.sv
// Self-checking bench for alu_mdu_controller: decode table, M-group results and
// latency against a 64-bit arithmetic reference, flush/reset and back-pressure.
module tb_alu_mdu_controller;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, flush, is_mdu, illegal, out_valid, out_ready;
  logic [1:0]       ALUOp;
  logic [6:0]       Funct7;
  logic [2:0]       Funct3;
  logic [3:0]       Operation;
  logic [WIDTH-1:0] src_a, src_b, md_result;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_mdu_controller #(.WIDTH(WIDTH), .HAS_MDU(1'b1)) dut (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
    .in_valid(in_valid), .in_ready(in_ready), .src_a(src_a), .src_b(src_b),
    .flush(flush), .Operation(Operation), .is_mdu(is_mdu), .illegal(illegal),
    .out_valid(out_valid), .out_ready(out_ready), .md_result(md_result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V funct3 meaning -> base-ALU code
  function automatic logic [3:0] ref_operation(input logic [1:0] aluop, input logic [6:0] f7,
                                               input logic [2:0] f3);
    if (aluop == 2'b00) return 4'b0010;
    if (aluop == 2'b01) return 4'b1000;
    if (aluop == 2'b11) return 4'b1101;
    case (f3)
      3'd0: return (f7 == 7'b0100000) ? 4'b0110 : 4'b0010;
      3'd1: return 4'b0100;
      3'd2: return 4'b1100;
      3'd3: return 4'b1110;
      3'd4: return 4'b0011;
      3'd5: return (f7 == 7'b0100000) ? 4'b0111 : 4'b0101;
      3'd6: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint     sp;
    logic [63:0] up;
    int         ia, ib;
    logic       ovf;
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin sp = longint'(ia) * longint'(ib); return sp[31:0]; end
      3'd1: begin sp = longint'(ia) * longint'(ib); return sp[63:32]; end
      3'd2: begin sp = longint'(ia) * longint'({32'b0, b}); return sp[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'h0 : ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    logic is_div, signed_div;
    is_div     = (f3 >= 3'd4);
    signed_div = (f3 == 3'd4) || (f3 == 3'd6);
    if (is_div && (b == 0)) return 2;
    if (signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return WIDTH + 1;
  endfunction

  task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int hold);
    int   cyc;
    logic busy_ready;
    @(negedge clk);
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f3;
    src_a = a; src_b = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    // upstream keeps presenting (changing) ops; they must be ignored while busy
    src_a = $urandom; src_b = $urandom; Funct3 = 3'($urandom);
    cyc = 0;
    busy_ready = 1'b0;
    while (!out_valid && cyc < 200) begin
      if (in_ready) busy_ready = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "/latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "/busy_ready"}, 64'(busy_ready), 64'd0);
    check({tag, "/result"}, 64'(md_result), 64'(exp));
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      check({tag, "/held_valid"}, 64'(out_valid), 64'd1);
      check({tag, "/held_ready"}, 64'(in_ready), 64'd0);
      check({tag, "/held_result"}, 64'(md_result), 64'(exp));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "/drain_ready"}, 64'(in_ready), 64'd1);
    check({tag, "/drain_valid"}, 64'(out_valid), 64'd0);
    check({tag, "/drain_result"}, 64'(md_result), 64'(exp));
  endtask

  initial begin
    logic [1:0]  aop;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a, b;

    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    ALUOp = 2'b00; Funct7 = '0; Funct3 = '0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/in_ready", 64'(in_ready), 64'd1);
    check("reset/out_valid", 64'(out_valid), 64'd0);
    check("reset/md_result", 64'(md_result), 64'd0);
    reset = 1'b0;

    ALUOp = 2'b10; Funct7 = 7'b0100000; Funct3 = 3'b000; #1;
    check("dec/sub", 64'(Operation), 64'h6);
    Funct3 = 3'b011; #1;
    check("dec/sltu", 64'(Operation), 64'hE);
    ALUOp = 2'b11; #1;
    check("dec/jal", 64'(Operation), 64'hD);
    for (int i = 0; i < 30; i++) begin
      aop = 2'($urandom);
      case ($urandom_range(0, 2))
        0: f7 = 7'b0000000;
        1: f7 = 7'b0100000;
        default: f7 = 7'($urandom);
      endcase
      if (aop == 2'b10 && f7 == 7'b0000001) f7 = 7'b0000000;
      f3 = 3'($urandom);
      ALUOp = aop; Funct7 = f7; Funct3 = f3; #1;
      check("dec/rand_op", 64'(Operation), 64'(ref_operation(aop, f7, f3)));
      check("dec/rand_not_mdu", 64'(is_mdu), 64'd0);
    end
    ALUOp = 2'b10; Funct7 = 7'b0000001; #1;
    check("dec/is_mdu", 64'(is_mdu), 64'd1);
    check("dec/illegal", 64'(illegal), 64'd0);

    run_md("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 5);
    run_md("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_md("mulhsu_-1x2", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_md("div_-7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run_md("rem_-7%2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_md("divu_5/0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 0);
    run_md("remu_5/0", 3'd7, 32'd5, 32'd0, 32'd5, 2, 1);
    run_md("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0);
    run_md("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2, 0);

    for (int i = 0; i < 14; i++) begin
      f3 = 3'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      run_md("rand", f3, a, b, ref_md(f3, a, b), ref_latency(f3, a, b), $urandom_range(0, 2));
    end

    // flush in the middle of a multiply, then flush blocking acceptance in IDLE
    @(negedge clk);
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'd0;
    src_a = 32'd3; src_b = 32'd5; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("flush/in_ready", 64'(in_ready), 64'd1);
    check("flush/out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("flush/idle_block", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("flush/no_result", 64'(out_valid), 64'd0);

    // reset mid-op dominates a simultaneous flush and new request
    @(negedge clk);
    Funct3 = 3'd1; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid/in_ready", 64'(in_ready), 64'd1);
    check("rst_mid/out_valid", 64'(out_valid), 64'd0);
    check("rst_mid/md_result", 64'(md_result), 64'd0);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    run_md("after_rst", 3'd5, 32'd100, 32'd7, 32'd14, 33, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
